axi4rd2axilrd: RTL and testbench

Converts AXI4 read bursts on a slave port into a sequence of single-beat AXI-lite reads on a master port. It sits directly upstream of the AXI-lite read-to-wishbone bridge and drives that bridge's AR and R channels. On the way back it re-attaches the burst ID and generates RLAST for the full-AXI master. One burst is handled at a time; individual beats are pipelined.

---
 rtl/axi4rd2axilrd_if.sv | 53 +++++
 rtl/axi4rd2axilrd.sv | 135 +++++++++++++
 tb/tb_axi4rd2axilrd.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4rd2axilrd_if.sv
// Bus bundle for the AXI4 read burst slave port and the AXI-lite read master port.
interface axi4rd2axilrd_if #(
    parameter int unsigned AW = 28,
    parameter int unsigned IW = 4
);
    localparam int unsigned DW = 32;

    // full AXI4 read slave side
    logic [IW-1:0] axi_arid;
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic [3:0]    axi_arcache;
    logic [2:0]    axi_arprot;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [IW-1:0] axi_rid;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;

    // AXI-lite read master side
    logic [AW-1:0] axil_araddr;
    logic [3:0]    axil_arcache;
    logic [2:0]    axil_arprot;
    logic          axil_arvalid;
    logic          axil_arready;
    logic [DW-1:0] axil_rdata;
    logic [1:0]    axil_rresp;
    logic          axil_rvalid;
    logic          axil_rready;

    // view of the converter itself
    modport slave (
        input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arcache, axi_arprot, axi_arvalid, axi_rready,
               axil_arready, axil_rdata, axil_rresp, axil_rvalid,
        output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
               axil_araddr, axil_arcache, axil_arprot, axil_arvalid, axil_rready
    );

    // view of the surrounding environment (burst master plus lite slave)
    modport master (
        output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
               axi_arcache, axi_arprot, axi_arvalid, axi_rready,
               axil_arready, axil_rdata, axil_rresp, axil_rvalid,
        input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
               axil_araddr, axil_arcache, axil_arprot, axil_arvalid, axil_rready
    );
endinterface

// File: rtl/axi4rd2axilrd.sv
// Splits one AXI4 read burst at a time into single-beat AXI-lite reads and
// re-attaches ID/RLAST on the returning data.
module axi4rd2axilrd #(
    parameter int unsigned C_AXI_ADDR_WIDTH = 28,
    parameter int unsigned C_AXI_ID_WIDTH   = 4
) (
    input logic            i_clk,
    input logic            i_axi_reset_n,
    axi4rd2axilrd_if.slave bus
);
    localparam int unsigned AW = C_AXI_ADDR_WIDTH;
    localparam int unsigned IW = C_AXI_ID_WIDTH;
    localparam int unsigned CW = 9;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        r_busy;
    state_t        busy_nxt;
    logic [IW-1:0] r_id;
    logic [7:0]    r_len;
    logic [1:0]    r_burst;
    logic [3:0]    r_cache;
    logic [2:0]    r_prot;
    logic [2:0]    r_step;
    logic [CW-1:0] r_issued;
    logic [CW-1:0] r_returned;
    logic [AW-1:0] r_araddr;
    logic          r_arvalid;

    logic          ar_hs_c;
    logic          lar_hs_c;
    logic          r_hs_c;
    logic          rlast_c;
    logic [2:0]    step_new_c;
    logic [AW-1:0] step_mask_c;
    logic [AW-1:0] aligned_c;
    logic [10:0]   wrap_bytes_c;
    logic [AW-1:0] wrap_mask_c;
    logic [AW-1:0] next_addr_c;

    assign ar_hs_c  = (r_busy == IDLE) && bus.axi_arvalid;
    assign lar_hs_c = r_arvalid && bus.axil_arready;
    assign rlast_c  = ({1'b0, r_len} == r_returned);
    assign r_hs_c   = (r_busy == BUSY) && bus.axil_rvalid && bus.axi_rready;

    // bytes per beat, sizes above a word are clamped to a word
    always_comb begin
        step_new_c = 3'd4;
        if (bus.axi_arsize == 3'd0)
            step_new_c = 3'd1;
        else if (bus.axi_arsize == 3'd1)
            step_new_c = 3'd2;
    end

    // next lite beat address for the captured burst type
    always_comb begin
        step_mask_c  = AW'(r_step) - AW'(1);
        aligned_c    = r_araddr & ~step_mask_c;
        wrap_bytes_c = 11'(({3'b000, r_len} + 11'd1) * {8'd0, r_step});
        wrap_mask_c  = AW'(wrap_bytes_c - 11'd1);
        next_addr_c  = aligned_c + AW'(r_step);
        case (r_burst)
            2'b00:   next_addr_c = r_araddr;
            2'b10:   next_addr_c = (r_araddr & ~wrap_mask_c) |
                                   ((aligned_c + AW'(r_step)) & wrap_mask_c);
            default: next_addr_c = aligned_c + AW'(r_step);
        endcase
    end

    // state register
    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n)
            r_busy <= IDLE;
        else
            r_busy <= busy_nxt;
    end

    // next state: leave IDLE on AR accept, return on the last R handshake
    always_comb begin
        busy_nxt = r_busy;
        case (r_busy)
            IDLE: if (bus.axi_arvalid) busy_nxt = BUSY;
            BUSY: if (r_hs_c && rlast_c) busy_nxt = IDLE;
        endcase
    end

    // burst capture, lite AR issue and beat counters
    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            r_id       <= '0;
            r_len      <= '0;
            r_burst    <= '0;
            r_cache    <= '0;
            r_prot     <= '0;
            r_step     <= 3'd1;
            r_issued   <= '0;
            r_returned <= '0;
            r_araddr   <= '0;
            r_arvalid  <= 1'b0;
        end else if (ar_hs_c) begin
            r_id       <= bus.axi_arid;
            r_len      <= bus.axi_arlen;
            r_burst    <= bus.axi_arburst;
            r_cache    <= bus.axi_arcache;
            r_prot     <= bus.axi_arprot;
            r_step     <= step_new_c;
            r_issued   <= '0;
            r_returned <= '0;
            r_araddr   <= bus.axi_araddr;
            r_arvalid  <= 1'b1;
        end else begin
            if (lar_hs_c) begin
                r_issued <= r_issued + CW'(1);
                if (r_issued == {1'b0, r_len})
                    r_arvalid <= 1'b0;
                else
                    r_araddr <= next_addr_c;
            end
            if (r_hs_c)
                r_returned <= r_returned + CW'(1);
        end
    end

    assign bus.axi_arready  = (r_busy == IDLE);
    assign bus.axi_rid      = r_id;
    assign bus.axi_rdata    = bus.axil_rdata;
    assign bus.axi_rresp    = bus.axil_rresp;
    assign bus.axi_rlast    = rlast_c;
    assign bus.axi_rvalid   = (r_busy == BUSY) && bus.axil_rvalid;
    assign bus.axil_rready  = (r_busy == BUSY) && bus.axi_rready;
    assign bus.axil_araddr  = r_araddr;
    assign bus.axil_arcache = r_cache;
    assign bus.axil_arprot  = r_prot;
    assign bus.axil_arvalid = r_arvalid;
endmodule

// File: tb/tb_axi4rd2axilrd.sv
// Bench for axi4rd2axilrd: acts as burst master and lite slave, checks against a
// burst-level model (expected address list, response queue, busy flag).
module tb_axi4rd2axilrd;
    localparam int unsigned AW = 28;
    localparam int unsigned IW = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4rd2axilrd_if #(.AW(AW), .IW(IW)) bus ();

    axi4rd2axilrd #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_ID_WIDTH(IW)) dut (
        .i_clk         (clk),
        .i_axi_reset_n (rst_n),
        .bus           (bus)
    );

    int total = 0;
    int bad = 0;

    // model state
    logic          m_busy = 1'b0;
    logic [IW-1:0] m_id;
    logic [3:0]    m_cache;
    logic [2:0]    m_prot;
    int            m_len = 0;
    int            m_ret = 0;
    logic [AW-1:0] exp_addr_q[$];
    rsp_t          exp_r_q[$];
    rsp_t          lite_q[$];
    logic          lite_r_hs = 1'b0;
    int            rseq = 0;
    int            ar_idx = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;

    // observation logs for directed checks
    logic [AW-1:0] obs_addr[$];
    logic [1:0]    obs_resp[$];
    int            obs_beats = 0;
    int            obs_last = 0;

    // stimulus knobs
    int ready_mode = 0;     // 0 always ready, 1 random, 2 alternating
    bit rand_lat = 1'b0;
    bit rand_resp = 1'b0;
    bit rready_low = 1'b0;
    int err_beat = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // expected lite address sequence straight from the burst rules
    task automatic gen_addrs(input logic [AW-1:0] a, input int len, input int size, input int burst);
        longint step, modv, al, tot, base, v;
        step = 64'(1) << ((size > 2) ? 2 : size);
        modv = 64'(1) << AW;
        al   = (longint'(a) / step) * step;
        tot  = longint'(len + 1) * step;
        base = (longint'(a) / tot) * tot;
        for (int i = 0; i <= len; i++) begin
            if (i == 0 || burst == 0)
                v = longint'(a);
            else if (burst == 2)
                v = base + ((al + longint'(i) * step) % tot);
            else
                v = (al + longint'(i) * step) % modv;
            exp_addr_q.push_back(AW'(v));
        end
    endtask

    // per-cycle compare and model update, sampled mid-cycle
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        rsp_t          e;
        rsp_t          n;
        logic          last;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ret = 0;
            exp_addr_q.delete();
            exp_r_q.delete();
            lite_q.delete();
            lite_r_hs = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("arready", bus.axi_arready, !m_busy);
            chk("lite_arvalid", bus.axil_arvalid, m_busy && (exp_addr_q.size() > 0));
            chk("lite_rready", bus.axil_rready, m_busy && bus.axi_rready);
            chk("axi_rvalid", bus.axi_rvalid, m_busy && bus.axil_rvalid);
            if (prev_stall)
                chk("ar_hold", {bus.axil_arvalid, bus.axil_araddr}, {1'b1, prev_addr});
            prev_stall = bus.axil_arvalid && !bus.axil_arready;
            prev_addr = bus.axil_araddr;
            if (bus.axil_arvalid && bus.axil_arready && exp_addr_q.size() > 0) begin
                ea = exp_addr_q.pop_front();
                chk("lite_araddr", bus.axil_araddr, ea);
                chk("lite_arcache", bus.axil_arcache, m_cache);
                chk("lite_arprot", bus.axil_arprot, m_prot);
                obs_addr.push_back(bus.axil_araddr);
                n.data = {16'(bus.axil_araddr) ^ 16'hBEEF, 16'(rseq)};
                n.resp = rand_resp ? 2'($urandom_range(0, 3)) : 2'b00;
                if (ar_idx == err_beat)
                    n.resp = 2'b10;
                rseq++;
                ar_idx++;
                exp_r_q.push_back(n);
                lite_q.push_back(n);
            end
            lite_r_hs = bus.axil_rvalid && bus.axil_rready;
            if (lite_r_hs) begin
                if (exp_r_q.size() == 0) begin
                    chk("r_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_r_q.pop_front();
                    last = (m_ret == m_len);
                    chk("rid", bus.axi_rid, m_id);
                    chk("rdata", bus.axi_rdata, e.data);
                    chk("rresp", bus.axi_rresp, e.resp);
                    chk("rlast", bus.axi_rlast, last);
                    obs_resp.push_back(bus.axi_rresp);
                    obs_beats++;
                    if (bus.axi_rlast)
                        obs_last++;
                    if (last) begin
                        m_busy = 1'b0;
                        m_ret = 0;
                    end else begin
                        m_ret++;
                    end
                end
            end
            if (bus.axi_arvalid && bus.axi_arready) begin
                m_busy = 1'b1;
                m_id = bus.axi_arid;
                m_len = int'(bus.axi_arlen);
                m_ret = 0;
                m_cache = bus.axi_arcache;
                m_prot = bus.axi_arprot;
                ar_idx = 0;
                gen_addrs(bus.axi_araddr, int'(bus.axi_arlen), int'(bus.axi_arsize),
                          int'(bus.axi_arburst));
            end
        end
    end

    // lite slave and ready drivers
    initial begin
        bit tog = 1'b0;
        bus.axil_arready = 1'b1;
        bus.axil_rvalid = 1'b0;
        bus.axil_rdata = '0;
        bus.axil_rresp = '0;
        bus.axi_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.axil_rvalid = 1'b0;
            end else begin
                if (lite_r_hs) begin
                    if (lite_q.size() > 0)
                        void'(lite_q.pop_front());
                    bus.axil_rvalid = 1'b0;
                end
                if (!bus.axil_rvalid && lite_q.size() > 0 &&
                    (!rand_lat || $urandom_range(0, 2) != 0)) begin
                    bus.axil_rvalid = 1'b1;
                    bus.axil_rdata = lite_q[0].data;
                    bus.axil_rresp = lite_q[0].resp;
                end
                tog = ~tog;
                case (ready_mode)
                    1:       bus.axil_arready = 1'($urandom_range(0, 1));
                    2:       bus.axil_arready = tog;
                    default: bus.axil_arready = 1'b1;
                endcase
                if (rready_low)
                    bus.axi_rready = 1'b0;
                else if (ready_mode == 1)
                    bus.axi_rready = ($urandom_range(0, 3) != 0);
                else
                    bus.axi_rready = 1'b1;
            end
        end
    end

    task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input int size, input int burst);
        int n = 0;
        @(posedge clk);
        #1;
        bus.axi_arid = id;
        bus.axi_araddr = addr;
        bus.axi_arlen = 8'(len);
        bus.axi_arsize = 3'(size);
        bus.axi_arburst = 2'(burst);
        bus.axi_arcache = 4'($urandom_range(0, 15));
        bus.axi_arprot = 3'($urandom_range(0, 7));
        bus.axi_arvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.axi_arready) break;
            n++;
            if (n > 50) begin
                chk("ar_accept_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.axi_arvalid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (m_busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (m_busy)
            chk("burst_timeout", 1'b0, 1'b1);
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_resp.delete();
        obs_beats = 0;
        obs_last = 0;
    endtask

    task automatic chk_addrs(input string name, input logic [AW-1:0] e[$]);
        chk({name, "_count"}, 64'(obs_addr.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < obs_addr.size(); i++)
            chk({name, "_addr"}, obs_addr[i], e[i]);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_arready", bus.axi_arready, 1'b1);
        chk("rst_lite_arvalid", bus.axil_arvalid, 1'b0);
        chk("rst_lite_araddr", bus.axil_araddr, '0);
        chk("rst_lite_arcache", bus.axil_arcache, 4'h0);
        chk("rst_lite_arprot", bus.axil_arprot, 3'h0);
        chk("rst_rid", bus.axi_rid, '0);
        chk("rst_rvalid", bus.axi_rvalid, 1'b0);
        chk("rst_lite_rready", bus.axil_rready, 1'b0);
        chk("rst_rlast", bus.axi_rlast, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] el[$];
        int len, size, burst, n;
        bus.axi_arid = '0;
        bus.axi_araddr = '0;
        bus.axi_arlen = '0;
        bus.axi_arsize = '0;
        bus.axi_arburst = '0;
        bus.axi_arcache = '0;
        bus.axi_arprot = '0;
        bus.axi_arvalid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs();
        @(posedge clk);
        #4;
        rst_n = 1'b1;

        // INCR word burst
        clear_obs();
        send_ar(4'h5, 28'h100, 3, 2, 1);
        wait_done(100);
        el = '{28'h100, 28'h104, 28'h108, 28'h10C};
        chk_addrs("incr", el);
        chk("incr_beats", 64'(obs_beats), 64'd4);
        chk("incr_lasts", 64'(obs_last), 64'd1);
        @(negedge clk);
        chk("incr_arready_after", bus.axi_arready, 1'b1);

        // WRAP word burst
        clear_obs();
        send_ar(4'h9, 28'h38, 3, 2, 2);
        wait_done(100);
        el = '{28'h38, 28'h3C, 28'h30, 28'h34};
        chk_addrs("wrap", el);

        // FIXED with alternating lite arready
        clear_obs();
        ready_mode = 2;
        send_ar(4'h2, 28'h20, 2, 2, 0);
        wait_done(100);
        el = '{28'h20, 28'h20, 28'h20};
        chk_addrs("fixed", el);
        ready_mode = 0;

        // R backpressure plus SLVERR on the second beat
        clear_obs();
        err_beat = 1;
        send_ar(4'h7, 28'h40, 3, 2, 1);
        repeat (1) @(negedge clk);
        rready_low = 1'b1;
        repeat (5) @(negedge clk);
        rready_low = 1'b0;
        wait_done(100);
        err_beat = -1;
        chk("err_beats", 64'(obs_beats), 64'd4);
        chk("err_lasts", 64'(obs_last), 64'd1);
        if (obs_resp.size() > 1)
            chk("err_resp_beat2", obs_resp[1], 2'b10);
        else
            chk("err_resp_missing", 1'b0, 1'b1);

        // abandon a max-length burst with async reset, then run one fully
        clear_obs();
        send_ar(4'h3, 28'h1000, 255, 2, 1);
        n = 0;
        while (obs_beats < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_progress", 64'(obs_beats >= 10), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
        clear_obs();
        send_ar(4'hA, 28'h2000, 255, 2, 1);
        wait_done(2000);
        chk("max_count", 64'(obs_addr.size()), 64'd256);
        if (obs_addr.size() == 256) begin
            chk("max_first", obs_addr[0], 28'h2000);
            chk("max_final", obs_addr[255], 28'h23FC);
        end
        chk("max_beats", 64'(obs_beats), 64'd256);
        chk("max_lasts", 64'(obs_last), 64'd1);

        // randomized bursts with random readiness, latency and responses
        ready_mode = 1;
        rand_lat = 1'b1;
        rand_resp = 1'b1;
        for (int b = 0; b < 40; b++) begin
            size = $urandom_range(0, 7);
            burst = $urandom_range(0, 3);
            if (burst == 2)
                len = (2 << $urandom_range(0, 3)) - 1;
            else if ($urandom_range(0, 5) == 0)
                len = 0;
            else
                len = $urandom_range(0, 20);
            clear_obs();
            if (b % 8 == 7)
                send_ar(4'($urandom_range(0, 15)), AW'(28'hFFFFFF0 | 28'($urandom_range(0, 15))),
                        len, size, burst);
            else
                send_ar(4'($urandom_range(0, 15)), AW'($urandom), len, size, burst);
            wait_done(3000);
            chk("rand_beats", 64'(obs_beats), 64'(len + 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
